// File: rtl/i2s_transmitter.sv
// I2S bus master: serializes stereo samples from a one-frame holding buffer onto BCLK/LRCLK/SDOUT.
// Data is MSB-first with a one-BCLK delay. SDOUT and LRCLK update only on BCLK falling edges.
module i2s_transmitter #(
  parameter int SAMPLE_WIDTH = 18,
  parameter int SLOT_BITS    = 32,
  parameter int BCLK_DIV     = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic signed [SAMPLE_WIDTH-1:0] sample_l,
  input  logic signed [SAMPLE_WIDTH-1:0] sample_r,
  input  logic                           sample_valid,
  output logic                           sample_ready,
  output logic                           BCLK,
  output logic                           LRCLK,
  output logic                           SDOUT,
  output logic                           frame_start,
  output logic                           underrun
);
  localparam int FRAME_BITS = 2 * SLOT_BITS;
  localparam int CNT_W      = $clog2(FRAME_BITS);
  localparam int DIV_W      = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_BITS - 1);
  localparam logic [CNT_W-1:0] CNT_SLOT = CNT_W'(SLOT_BITS);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);

  logic [DIV_W-1:0]               div_cnt_q, div_cnt_d;
  logic [CNT_W-1:0]               bit_cnt_q, bit_cnt_d;
  logic                           bclk_q, bclk_d;
  logic                           lrclk_q, lrclk_d;
  logic                           sdout_q, sdout_d;
  logic                           frame_start_q, frame_start_d;
  logic                           underrun_q, underrun_d;
  logic                           hold_full_q, hold_full_d;
  logic signed [SAMPLE_WIDTH-1:0] hold_l_q, hold_l_d, hold_r_q, hold_r_d;
  logic signed [SAMPLE_WIDTH-1:0] frame_l_q, frame_l_d, frame_r_q, frame_r_d;
  logic signed [SAMPLE_WIDTH-1:0] slot;
  logic                           div_end, fall, load, accept;
  int                             k;

  always_comb begin
    div_end       = (div_cnt_q == DIV_LAST);
    fall          = div_end && bclk_q;
    load          = fall && (bit_cnt_q == CNT_LAST);
    accept        = sample_valid && !hold_full_q;
    div_cnt_d     = div_end ? '0 : div_cnt_q + 1'b1;
    bclk_d        = div_end ? ~bclk_q : bclk_q;
    bit_cnt_d     = bit_cnt_q;
    lrclk_d       = lrclk_q;
    sdout_d       = sdout_q;
    frame_start_d = 1'b0;
    underrun_d    = 1'b0;
    frame_l_d     = frame_l_q;
    frame_r_d     = frame_r_q;
    hold_l_d      = hold_l_q;
    hold_r_d      = hold_r_q;
    slot          = '0;
    k             = 0;

    if (fall) begin
      bit_cnt_d = (bit_cnt_q == CNT_LAST) ? '0 : bit_cnt_q + 1'b1;
      lrclk_d   = (bit_cnt_d >= CNT_SLOT);
      k         = int'(bit_cnt_d) % SLOT_BITS;
      slot      = lrclk_d ? frame_r_q : frame_l_q;
      // Slot position 0 is the one-BCLK delay; positions past the sample are padding zeros.
      sdout_d   = 1'b0;
      for (int i = 0; i < SAMPLE_WIDTH; i++) begin
        if (k == SAMPLE_WIDTH - i) sdout_d = slot[i];
      end
    end

    if (load) begin
      frame_start_d = 1'b1;
      if (hold_full_q) begin
        frame_l_d = hold_l_q;
        frame_r_d = hold_r_q;
      end else begin
        frame_l_d  = '0;
        frame_r_d  = '0;
        underrun_d = 1'b1;
      end
    end

    if (accept) begin
      hold_l_d = sample_l;
      hold_r_d = sample_r;
    end
    // An accept coinciding with an empty-buffer load keeps the new pair for the next frame.
    hold_full_d = accept || (hold_full_q && !load);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_cnt_q     <= '0;
      bit_cnt_q     <= CNT_LAST;
      bclk_q        <= 1'b0;
      lrclk_q       <= 1'b0;
      sdout_q       <= 1'b0;
      frame_start_q <= 1'b0;
      underrun_q    <= 1'b0;
      hold_full_q   <= 1'b0;
      hold_l_q      <= '0;
      hold_r_q      <= '0;
      frame_l_q     <= '0;
      frame_r_q     <= '0;
    end else begin
      div_cnt_q     <= div_cnt_d;
      bit_cnt_q     <= bit_cnt_d;
      bclk_q        <= bclk_d;
      lrclk_q       <= lrclk_d;
      sdout_q       <= sdout_d;
      frame_start_q <= frame_start_d;
      underrun_q    <= underrun_d;
      hold_full_q   <= hold_full_d;
      hold_l_q      <= hold_l_d;
      hold_r_q      <= hold_r_d;
      frame_l_q     <= frame_l_d;
      frame_r_q     <= frame_r_d;
    end
  end

  assign sample_ready = ~hold_full_q;
  assign BCLK         = bclk_q;
  assign LRCLK        = lrclk_q;
  assign SDOUT        = sdout_q;
  assign frame_start  = frame_start_q;
  assign underrun     = underrun_q;
endmodule

// File: tb/tb_i2s_transmitter.sv
// Testbench for i2s_transmitter at default parameters: scenario tasks plus a frame scoreboard
// that deserializes SDOUT on BCLK rising edges and compares each frame with the expected pair.
module tb_i2s_transmitter;
  logic        clk;
  logic        reset;
  logic [17:0] sample_l;
  logic [17:0] sample_r;
  logic        sample_valid;
  logic        sample_ready;
  logic        BCLK;
  logic        LRCLK;
  logic        SDOUT;
  logic        frame_start;
  logic        underrun;

  typedef struct packed {
    logic [17:0] l;
    logic [17:0] r;
    logic        und;
  } frame_t;

  frame_t sb[$];
  int     n_pass;
  int     n_total;

  i2s_transmitter dut (
    .clk          (clk),
    .reset        (reset),
    .sample_l     (sample_l),
    .sample_r     (sample_r),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .BCLK         (BCLK),
    .LRCLK        (LRCLK),
    .SDOUT        (SDOUT),
    .frame_start  (frame_start),
    .underrun     (underrun)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
    $fatal(1);
  end

  // Frame image indexed by BCLK position within the frame: position k of a slot carries bit 18-k.
  function automatic logic [63:0] exp_frame(input logic [17:0] l, input logic [17:0] r);
    logic [17:0] lrev;
    logic [17:0] rrev;
    lrev = {<<{l}};
    rrev = {<<{r}};
    return {13'b0, rrev, 1'b0, 13'b0, lrev, 1'b0};
  endfunction

  task automatic monitor();
    logic [63:0] got;
    logic [63:0] exp;
    frame_t      e;
    int          n;
    int          lr_err;
    bit          coll;
    logic        und;
    logic        bprev;
    got = '0; n = 0; lr_err = 0; coll = 0; und = 0; bprev = 0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        coll  = 0;
        bprev = 0;
      end else begin
        if (frame_start) begin
          coll = 1; n = 0; got = '0; und = underrun; lr_err = 0;
        end
        if (coll && BCLK && !bprev) begin
          got = {SDOUT, got[63:1]};
          if (LRCLK !== (n >= 32)) lr_err++;
          n++;
          if (n == 64) begin
            coll = 0;
            if (sb.size() > 0) e = sb.pop_front();
            else e = '{l: 18'h0, r: 18'h0, und: 1'b1};
            exp = exp_frame(e.l, e.r);
            n_total++;
            if (got !== exp || und !== e.und || lr_err != 0)
              $display("FAIL frame: got bits %h und=%b lrclk_errors=%0d, expected bits %h und=%b lrclk_errors=0",
                       got, und, lr_err, exp, e.und);
            else n_pass++;
          end
        end
        bprev = BCLK;
      end
    end
  endtask

  task automatic apply_reset(input logic v, input logic [17:0] l, input logic [17:0] r);
    reset        = 1'b0;
    sample_valid = v;
    sample_l     = l;
    sample_r     = r;
    sb.delete();
    repeat (10) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic wait_fs(output bit ok);
    ok = 0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (frame_start) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int since;
    int tog_err;
    int unds;
    logic bprev;
    reset = 1'b0; sample_valid = 1'b0; sample_l = '0; sample_r = '0;
    sb.delete();
    repeat (10) @(negedge clk);
    n_total++;
    if ({BCLK, LRCLK, SDOUT, sample_ready, frame_start, underrun} !== 6'b000100)
      $display("FAIL reset_outputs: got %b, expected 000100",
               {BCLK, LRCLK, SDOUT, sample_ready, frame_start, underrun});
    else n_pass++;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_total++;
    if (BCLK !== 1'b0) $display("FAIL bclk_edge3: got %b, expected 0", BCLK);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (BCLK !== 1'b1) $display("FAIL bclk_edge4: got %b, expected 1", BCLK);
    else n_pass++;
    repeat (4) @(negedge clk);
    n_total++;
    if ({BCLK, frame_start, underrun, LRCLK, SDOUT} !== 5'b01100)
      $display("FAIL first_load: got %b, expected 01100", {BCLK, frame_start, underrun, LRCLK, SDOUT});
    else n_pass++;
    since = 0; tog_err = 0; unds = 0; bprev = BCLK;
    for (int i = 0; i < 1024; i++) begin
      @(negedge clk);
      since++;
      if (BCLK !== bprev) begin
        if (since != 4) tog_err++;
        since = 0;
      end
      bprev = BCLK;
      if (underrun) unds++;
    end
    n_total++;
    if (tog_err != 0) $display("FAIL bclk_period: got %0d bad half-periods, expected 0", tog_err);
    else n_pass++;
    n_total++;
    if (unds != 2) $display("FAIL idle_underruns: got %0d pulses in 1024 clk, expected 2", unds);
    else n_pass++;
  endtask

  task automatic test_single_frame();
    apply_reset(1'b1, 18'h2A5A5, 18'h1C003);
    sb.push_back('{l: 18'h2A5A5, r: 18'h1C003, und: 1'b0});
    @(negedge clk);
    n_total++;
    if (sample_ready !== 1'b0) $display("FAIL single_accept: sample_ready got %b, expected 0", sample_ready);
    else n_pass++;
    sample_valid = 1'b0;
    repeat (7) @(negedge clk);
    n_total++;
    if ({frame_start, underrun, sample_ready} !== 3'b101)
      $display("FAIL single_load: frame_start/underrun/ready got %b, expected 101",
               {frame_start, underrun, sample_ready});
    else n_pass++;
    repeat (530) @(negedge clk);
    n_total++;
    if (sb.size() != 0) $display("FAIL single_drain: got %0d pending frames, expected 0", sb.size());
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int   idx, acc, unds, rdy_err, fs, cyc;
    bit   in_wait;
    logic prev_ready;
    apply_reset(1'b1, 18'h12345, 18'h2ABCD);
    idx = 0; acc = 0; unds = 0; rdy_err = 0; fs = 0; cyc = 0; in_wait = 0;
    prev_ready = sample_ready;
    while (fs < 8 && cyc < 5000) begin
      @(negedge clk);
      cyc++;
      if (sample_valid && prev_ready) begin
        sb.push_back('{l: sample_l, r: sample_r, und: 1'b0});
        acc++;
        in_wait = 1;
        idx++;
        sample_l = 18'(32'h12345 + idx);
        sample_r = 18'(32'h2ABCD - idx);
      end
      if (frame_start) begin
        fs++;
        in_wait = 0;
        if (underrun) unds++;
        if (fs == 8) sample_valid = 1'b0;
      end
      if (in_wait && sample_ready !== 1'b0) rdy_err++;
      prev_ready = sample_ready;
    end
    n_total++;
    if (fs != 8) $display("FAIL b2b_frames: got %0d frame_starts, expected 8", fs);
    else n_pass++;
    n_total++;
    if (acc != 8) $display("FAIL b2b_accepts: got %0d accepts, expected 8", acc);
    else n_pass++;
    n_total++;
    if (unds != 0) $display("FAIL b2b_underrun: got %0d underruns, expected 0", unds);
    else n_pass++;
    n_total++;
    if (rdy_err != 0) $display("FAIL b2b_ready_low: got %0d cycles with ready high, expected 0", rdy_err);
    else n_pass++;
    repeat (530) @(negedge clk);
    n_total++;
    if (sb.size() != 0) $display("FAIL b2b_drain: got %0d pending frames, expected 0", sb.size());
    else n_pass++;
  endtask

  task automatic test_underrun();
    bit ok;
    apply_reset(1'b1, 18'h3C00F, 18'h00FF0);
    sb.push_back('{l: 18'h3C00F, r: 18'h00FF0, und: 1'b0});
    @(negedge clk);
    sample_valid = 1'b0;
    sb.push_back('{l: 18'h0, r: 18'h0, und: 1'b1});
    wait_fs(ok);
    n_total++;
    if (!ok || underrun !== 1'b0) $display("FAIL ur_frame1: found=%0d underrun=%b, expected found=1 underrun=0", ok, underrun);
    else n_pass++;
    wait_fs(ok);
    n_total++;
    if (!ok || underrun !== 1'b1) $display("FAIL ur_frame2: found=%0d underrun=%b, expected found=1 underrun=1", ok, underrun);
    else n_pass++;
    sample_l = 18'h21084; sample_r = 18'h1EF7B; sample_valid = 1'b1;
    sb.push_back('{l: 18'h21084, r: 18'h1EF7B, und: 1'b0});
    @(negedge clk);
    n_total++;
    if (sample_ready !== 1'b0) $display("FAIL ur_accept: sample_ready got %b, expected 0", sample_ready);
    else n_pass++;
    sample_valid = 1'b0;
    wait_fs(ok);
    n_total++;
    if (!ok || underrun !== 1'b0) $display("FAIL ur_frame3: found=%0d underrun=%b, expected found=1 underrun=0", ok, underrun);
    else n_pass++;
    repeat (530) @(negedge clk);
    n_total++;
    if (sb.size() != 0) $display("FAIL ur_drain: got %0d pending frames, expected 0", sb.size());
    else n_pass++;
  endtask

  task automatic test_simul_load_accept();
    bit ok;
    apply_reset(1'b0, 18'h35AC3, 18'h0A53C);
    repeat (7) @(negedge clk);
    sample_valid = 1'b1;
    sb.push_back('{l: 18'h0, r: 18'h0, und: 1'b1});
    sb.push_back('{l: 18'h35AC3, r: 18'h0A53C, und: 1'b0});
    @(negedge clk);
    n_total++;
    if ({frame_start, underrun, sample_ready} !== 3'b110)
      $display("FAIL simul_load: frame_start/underrun/ready got %b, expected 110",
               {frame_start, underrun, sample_ready});
    else n_pass++;
    sample_valid = 1'b0;
    wait_fs(ok);
    n_total++;
    if (!ok || {underrun, sample_ready} !== 2'b01)
      $display("FAIL simul_next: found=%0d underrun/ready=%b, expected found=1 underrun/ready=01",
               ok, {underrun, sample_ready});
    else n_pass++;
    repeat (530) @(negedge clk);
    n_total++;
    if (sb.size() != 0) $display("FAIL simul_drain: got %0d pending frames, expected 0", sb.size());
    else n_pass++;
  endtask

  task automatic test_reset_mid_frame();
    apply_reset(1'b1, 18'h3FFFF, 18'h3FFFF);
    sb.push_back('{l: 18'h3FFFF, r: 18'h3FFFF, und: 1'b0});
    @(negedge clk);
    sample_l = 18'h15555; sample_r = 18'h0AAAA;
    repeat (8) @(negedge clk);
    sample_valid = 1'b0;
    sb.push_back('{l: 18'h15555, r: 18'h0AAAA, und: 1'b0});
    repeat (339) @(negedge clk);
    n_total++;
    if ({BCLK, LRCLK, SDOUT, sample_ready} !== 4'b1110)
      $display("FAIL mid_precondition: BCLK/LRCLK/SDOUT/ready got %b, expected 1110",
               {BCLK, LRCLK, SDOUT, sample_ready});
    else n_pass++;
    reset = 1'b0;
    #1;
    n_total++;
    if ({BCLK, LRCLK, SDOUT, sample_ready, frame_start, underrun} !== 6'b000100)
      $display("FAIL mid_async_reset: got %b, expected 000100",
               {BCLK, LRCLK, SDOUT, sample_ready, frame_start, underrun});
    else n_pass++;
    sb.delete();
    repeat (10) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_total++;
    if (BCLK !== 1'b0) $display("FAIL mid_bclk_edge3: got %b, expected 0", BCLK);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (BCLK !== 1'b1) $display("FAIL mid_bclk_edge4: got %b, expected 1", BCLK);
    else n_pass++;
    repeat (4) @(negedge clk);
    n_total++;
    if ({BCLK, frame_start, underrun, LRCLK, SDOUT} !== 5'b01100)
      $display("FAIL mid_first_load: got %b, expected 01100", {BCLK, frame_start, underrun, LRCLK, SDOUT});
    else n_pass++;
    repeat (520) @(negedge clk);
    n_total++;
    if (sb.size() != 0) $display("FAIL mid_drain: got %0d pending frames, expected 0", sb.size());
    else n_pass++;
  endtask

  initial begin
    n_pass       = 0;
    n_total      = 0;
    reset        = 1'b0;
    sample_valid = 1'b0;
    sample_l     = '0;
    sample_r     = '0;
    fork
      monitor();
    join_none
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_underrun();
    test_simul_load_accept();
    test_reset_mid_frame();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
